// File: rtl/host_cmd_wb_master_pkg.sv
// Shared host-command definitions: opcodes, response status encoding and FSM types
// used by the Wishbone master, its bus interface and the ack timer.
package host_cmd_wb_master_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 28;
    localparam int unsigned SEL_W   = 4;

    localparam logic [3:0] OP_PING  = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_RESET = 4'd3;

    localparam logic [3:0]       STATUS_UNKNOWN = 4'hB;
    localparam logic [SEL_W-1:0] WB_SEL_ALL     = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS_WR,
        S_WR_WAIT,
        S_BUS_RD,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  status;
        logic [DATA_W-1:0]  address;
        logic [COUNT_W-1:0] count;
        logic [DATA_W-1:0]  data;
    } resp_t;

    // Known opcodes report their own complement; everything else reports 4'hB.
    function automatic logic [DATA_W-1:0] status_word(input logic [3:0] op, input logic tmo);
        logic [3:0] code;
        code = (op[3:2] == 2'b00) ? ~op : STATUS_UNKNOWN;
        return {24'h0, 3'b000, tmo, code};
    endfunction

    // A data count of zero still moves one word.
    function automatic logic [COUNT_W-1:0] word_count(input logic [COUNT_W-1:0] cnt);
        return (cnt == '0) ? {{(COUNT_W-1){1'b0}}, 1'b1} : cnt;
    endfunction

endpackage

// File: rtl/host_cmd_wb_master_if.sv
// Wishbone master/slave signal bundle driven by host_cmd_wb_master.
interface host_cmd_wb_master_if;
    import host_cmd_wb_master_pkg::*;

    logic [DATA_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic              wbm_stb_o;
    logic              wbm_cyc_o;
    logic              wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/host_cmd_wb_master_wb_ack_timer.sv
// Counts cycles while a bus strobe is outstanding; flags expiry in the TIMEOUT-th cycle.
module wb_ack_timer #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic ack_i,
    output logic expired_o
);

    logic [15:0] cnt_q, cnt_d;

    // The first strobe cycle counts as cycle one, so expiry lands on cycle TIMEOUT.
    assign expired_o = start_i && !ack_i && (({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT});

    always_comb begin
        cnt_d = cnt_q;
        if (!start_i || ack_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/host_cmd_wb_master.sv
// Host command engine: decodes PING/WRITE/READ/RESET commands, runs Wishbone
// single accesses with an ack timeout and hands responses back over oh_ready/oh_en.
module host_cmd_wb_master
    import host_cmd_wb_master_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                master_ready,
    input  logic                ih_ready,
    input  logic                ih_reset,
    input  logic [DATA_W-1:0]   in_command,
    input  logic [DATA_W-1:0]   in_address,
    input  logic [COUNT_W-1:0]  in_data_count,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                oh_ready,
    output logic                oh_en,
    output logic [DATA_W-1:0]   out_status,
    output logic [DATA_W-1:0]   out_address,
    output logic [COUNT_W-1:0]  out_data_count,
    output logic [DATA_W-1:0]   out_data,
    host_cmd_wb_master_if.master wb
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [DATA_W-1:0]  start_adr_q, start_adr_d;
    logic [DATA_W-1:0]  bus_adr_q, bus_adr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [COUNT_W-1:0] words_q, words_d;
    logic               tmo_q, tmo_d;
    resp_t              rsp_q, rsp_d;
    resp_t              out_q;
    resp_t              out_view;
    logic               bus_act;
    logic               tmr_expired;
    logic               unused_cmd_bits;

    assign unused_cmd_bits = ^in_command[DATA_W-1:4];

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (bus_act),
        .ack_i     (wb.wbm_ack_i),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        start_adr_d = start_adr_q;
        bus_adr_d   = bus_adr_q;
        wdata_d     = wdata_q;
        words_d     = words_q;
        tmo_d       = tmo_q;
        rsp_d       = rsp_q;
        if (ih_reset) begin
            // Also taken in RESP: it rewrites the pending response instead of queueing one.
            state_d        = S_RESP;
            op_d           = OP_RESET;
            start_adr_d    = '0;
            bus_adr_d      = '0;
            wdata_d        = '0;
            words_d        = '0;
            tmo_d          = 1'b0;
            rsp_d          = '0;
            rsp_d.status   = status_word(OP_RESET, 1'b0);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ih_ready) begin
                        op_d         = in_command[3:0];
                        tmo_d        = 1'b0;
                        start_adr_d  = in_address;
                        bus_adr_d    = in_address;
                        wdata_d      = in_data;
                        words_d      = word_count(in_data_count);
                        rsp_d        = '0;
                        rsp_d.status = status_word(in_command[3:0], 1'b0);
                        case (in_command[3:0])
                            OP_WRITE: state_d = S_BUS_WR;
                            OP_READ:  state_d = S_BUS_RD;
                            default: begin
                                state_d = S_RESP;
                                words_d = '0;
                            end
                        endcase
                    end
                end
                S_BUS_WR: begin
                    if (wb.wbm_ack_i) begin
                        bus_adr_d = bus_adr_q + 32'd1;
                        words_d   = words_q - 28'd1;
                        if (words_q <= 28'd1) begin
                            state_d       = S_RESP;
                            rsp_d.status  = status_word(op_q, 1'b0);
                            rsp_d.address = start_adr_q;
                            rsp_d.data    = wdata_q;
                            rsp_d.count   = '0;
                        end else begin
                            state_d = S_WR_WAIT;
                        end
                    end else if (tmr_expired) begin
                        state_d       = S_RESP;
                        tmo_d         = 1'b1;
                        words_d       = '0;
                        rsp_d.status  = status_word(op_q, 1'b1);
                        rsp_d.address = start_adr_q;
                        rsp_d.data    = '0;
                        rsp_d.count   = '0;
                    end
                end
                S_WR_WAIT: begin
                    if (ih_ready) begin
                        wdata_d = in_data;
                        state_d = S_BUS_WR;
                    end
                end
                S_BUS_RD: begin
                    if (wb.wbm_ack_i) begin
                        state_d       = S_RESP;
                        bus_adr_d     = bus_adr_q + 32'd1;
                        words_d       = words_q - 28'd1;
                        rsp_d.status  = status_word(op_q, 1'b0);
                        rsp_d.address = start_adr_q;
                        rsp_d.data    = wb.wbm_dat_i;
                        rsp_d.count   = words_q - 28'd1;
                    end else if (tmr_expired) begin
                        state_d       = S_RESP;
                        tmo_d         = 1'b1;
                        words_d       = '0;
                        rsp_d.status  = status_word(op_q, 1'b1);
                        rsp_d.address = start_adr_q;
                        rsp_d.data    = '0;
                        rsp_d.count   = '0;
                    end
                end
                S_RESP: begin
                    if (oh_ready) begin
                        state_d = (op_q == OP_READ && words_q != '0) ? S_BUS_RD : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_PING;
            start_adr_q <= '0;
            bus_adr_q   <= '0;
            wdata_q     <= '0;
            words_q     <= '0;
            tmo_q       <= 1'b0;
            rsp_q       <= '0;
            out_q       <= '0;
        end else begin
            op_q        <= op_d;
            start_adr_q <= start_adr_d;
            bus_adr_q   <= bus_adr_d;
            wdata_q     <= wdata_d;
            words_q     <= words_d;
            tmo_q       <= tmo_d;
            rsp_q       <= rsp_d;
            if (oh_en) begin
                out_q <= rsp_q;
            end
        end
    end

    always_comb begin
        bus_act      = (state_q == S_BUS_WR || state_q == S_BUS_RD) && !rst;
        master_ready = (state_q == S_IDLE || state_q == S_WR_WAIT) && !rst;
        oh_en        = (state_q == S_RESP) && oh_ready && !ih_reset && !rst;
        // New response shows during its oh_en cycle and is held until the next one.
        out_view     = rst ? '0 : (oh_en ? rsp_q : out_q);

        out_status     = out_view.status;
        out_address    = out_view.address;
        out_data_count = out_view.count;
        out_data       = out_view.data;

        wb.wbm_cyc_o = bus_act;
        wb.wbm_stb_o = bus_act;
        wb.wbm_we_o  = bus_act && (state_q == S_BUS_WR);
        wb.wbm_sel_o = bus_act ? WB_SEL_ALL : '0;
        wb.wbm_adr_o = bus_act ? bus_adr_q : '0;
        wb.wbm_dat_o = (bus_act && state_q == S_BUS_WR) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_host_cmd_wb_master.sv
// Directed bench for host_cmd_wb_master with a zero-wait Wishbone slave and a response monitor.
module tb_host_cmd_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        master_ready;
    logic        ih_ready;
    logic        ih_reset;
    logic [31:0] in_command;
    logic [31:0] in_address;
    logic [27:0] in_data_count;
    logic [31:0] in_data;
    logic        oh_ready;
    logic        oh_en;
    logic [31:0] out_status;
    logic [31:0] out_address;
    logic [27:0] out_data_count;
    logic [31:0] out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    host_cmd_wb_master_if wbif ();

    host_cmd_wb_master #(
        .TIMEOUT (16'd8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .master_ready   (master_ready),
        .ih_ready       (ih_ready),
        .ih_reset       (ih_reset),
        .in_command     (in_command),
        .in_address     (in_address),
        .in_data_count  (in_data_count),
        .in_data        (in_data),
        .oh_ready       (oh_ready),
        .oh_en          (oh_en),
        .out_status     (out_status),
        .out_address    (out_address),
        .out_data_count (out_data_count),
        .out_data       (out_data),
        .wb             (wbif.master)
    );

    // Slave: acks one cycle per access, logs every access, returns rd_vals in order.
    logic        slave_en = 1'b0;
    logic [31:0] rd_vals [4];
    int          rd_idx = 0;
    int          n_acc  = 0;
    logic [31:0] acc_adr [16];
    logic [31:0] acc_dat [16];
    logic        acc_we  [16];

    initial begin
        wbif.wbm_ack_i = 1'b0;
        wbif.wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (wbif.wbm_ack_i) begin
                wbif.wbm_ack_i = 1'b0;
            end else if (slave_en && wbif.wbm_cyc_o && wbif.wbm_stb_o) begin
                wbif.wbm_ack_i = 1'b1;
                if (!wbif.wbm_we_o) begin
                    wbif.wbm_dat_i = rd_vals[rd_idx % 4];
                    rd_idx++;
                end
                if (n_acc < 16) begin
                    acc_adr[n_acc] = wbif.wbm_adr_o;
                    acc_dat[n_acc] = wbif.wbm_dat_o;
                    acc_we[n_acc]  = wbif.wbm_we_o;
                end
                n_acc++;
            end
        end
    end

    // Monitor: records each response, counts cyc cycles, flags out_* changes between pulses.
    int          n_resp     = 0;
    int          cyc_cycles = 0;
    int          stab_err   = 0;
    logic [31:0] r_status [32];
    logic [31:0] r_adr    [32];
    logic [31:0] r_data   [32];
    logic [27:0] r_cnt    [32];
    logic [31:0] h_status = 32'h0;
    logic [31:0] h_adr    = 32'h0;
    logic [31:0] h_data   = 32'h0;
    logic [27:0] h_cnt    = 28'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                h_status = 32'h0; h_adr = 32'h0; h_data = 32'h0; h_cnt = 28'h0;
            end else begin
                if (wbif.wbm_cyc_o) cyc_cycles++;
                if (oh_en) begin
                    if (n_resp < 32) begin
                        r_status[n_resp] = out_status;
                        r_adr[n_resp]    = out_address;
                        r_data[n_resp]   = out_data;
                        r_cnt[n_resp]    = out_data_count;
                    end
                    n_resp++;
                    h_status = out_status; h_adr = out_address; h_data = out_data; h_cnt = out_data_count;
                end else if ({out_status, out_address, out_data, out_data_count} !==
                             {h_status, h_adr, h_data, h_cnt}) begin
                    stab_err++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] cmd, input logic [31:0] adr,
                        input logic [27:0] cnt, input logic [31:0] dat);
        int i;
        i = 0;
        while (!master_ready && i < 40) begin
            step();
            i++;
        end
        chk("send_master_ready", {31'b0, master_ready}, 32'd1);
        in_command    = cmd;
        in_address    = adr;
        in_data_count = cnt;
        in_data       = dat;
        ih_ready      = 1'b1;
        step();
        ih_ready      = 1'b0;
    endtask

    task automatic wait_resp(input int target, input string tag);
        int i;
        i = 0;
        while (n_resp < target && i < 60) begin
            step();
            i++;
        end
        chk(tag, n_resp, target);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int a, b, c0, s0;

    initial begin
        rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33; rd_vals[3] = 32'h44;
        rst = 1'b1; ih_ready = 1'b0; ih_reset = 1'b0; oh_ready = 1'b0;
        in_command = '0; in_address = '0; in_data_count = '0; in_data = '0;
        idle(2);
        chk("rst_master_ready", {31'b0, master_ready}, 32'd0);
        chk("rst_oh_en", {31'b0, oh_en}, 32'd0);
        chk("rst_cyc", {31'b0, wbif.wbm_cyc_o}, 32'd0);
        chk("rst_sel", {28'b0, wbif.wbm_sel_o}, 32'd0);
        chk("rst_out_status", out_status, 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_master_ready", {31'b0, master_ready}, 32'd1);

        // PING
        oh_ready = 1'b1; b = n_resp; c0 = cyc_cycles;
        send(32'h0, 32'h0, 28'd0, 32'h0);
        wait_resp(b + 1, "ping_resp");
        idle(4);
        chk("ping_one_pulse", n_resp, b + 1);
        chk("ping_status", r_status[b], 32'h0F);
        chk("ping_addr", r_adr[b], 32'h0);
        chk("ping_data", r_data[b], 32'h0);
        chk("ping_no_cyc", cyc_cycles - c0, 32'd0);

        // Unknown opcode
        b = n_resp;
        send(32'h7, 32'h55, 28'd4, 32'h66);
        wait_resp(b + 1, "unk_resp");
        chk("unk_status", r_status[b], 32'h0B);
        chk("unk_count", {4'b0, r_cnt[b]}, 32'h0);

        // WRITE 3 words at 0x100
        slave_en = 1'b1; a = n_acc; b = n_resp;
        send(32'h1, 32'h100, 28'd3, 32'hA);
        send(32'h0, 32'h0, 28'd0, 32'hB);
        send(32'h0, 32'h0, 28'd0, 32'hC);
        wait_resp(b + 1, "wr_resp");
        idle(3);
        chk("wr_n_acc", n_acc - a, 32'd3);
        chk("wr_adr0", acc_adr[a], 32'h100);
        chk("wr_dat0", acc_dat[a], 32'hA);
        chk("wr_we0", {31'b0, acc_we[a]}, 32'd1);
        chk("wr_adr1", acc_adr[a+1], 32'h101);
        chk("wr_dat1", acc_dat[a+1], 32'hB);
        chk("wr_adr2", acc_adr[a+2], 32'h102);
        chk("wr_dat2", acc_dat[a+2], 32'hC);
        chk("wr_one_resp", n_resp, b + 1);
        chk("wr_status", r_status[b], 32'h0E);
        chk("wr_addr", r_adr[b], 32'h100);
        chk("wr_data", r_data[b], 32'hC);
        chk("wr_count", {4'b0, r_cnt[b]}, 32'h0);

        // READ 2 words at 0x20
        a = n_acc; b = n_resp;
        send(32'h2, 32'h20, 28'd2, 32'h0);
        wait_resp(b + 2, "rd_resp");
        idle(3);
        chk("rd_two_resp", n_resp, b + 2);
        chk("rd_adr0", acc_adr[a], 32'h20);
        chk("rd_we0", {31'b0, acc_we[a]}, 32'd0);
        chk("rd_adr1", acc_adr[a+1], 32'h21);
        chk("rd_status0", r_status[b], 32'h0D);
        chk("rd_data0", r_data[b], 32'h11);
        chk("rd_count0", {4'b0, r_cnt[b]}, 32'd1);
        chk("rd_addr0", r_adr[b], 32'h20);
        chk("rd_data1", r_data[b+1], 32'h22);
        chk("rd_count1", {4'b0, r_cnt[b+1]}, 32'd0);
        chk("rd_addr1", r_adr[b+1], 32'h20);

        // READ with no ack: timeout after 8 cycles
        slave_en = 1'b0; b = n_resp; c0 = cyc_cycles;
        send(32'h2, 32'h40, 28'd1, 32'h0);
        wait_resp(b + 1, "tmo_resp");
        chk("tmo_cyc_cycles", cyc_cycles - c0, 32'd8);
        chk("tmo_status", r_status[b], 32'h1D);
        chk("tmo_data", r_data[b], 32'h0);
        chk("tmo_count", {4'b0, r_cnt[b]}, 32'h0);

        // ih_reset with ih_ready during BUS_WR
        a = n_acc; b = n_resp;
        send(32'h1, 32'h300, 28'd1, 32'h55);
        chk("hrst_cyc_on", {31'b0, wbif.wbm_cyc_o}, 32'd1);
        ih_reset = 1'b1; ih_ready = 1'b1;
        step();
        ih_reset = 1'b0; ih_ready = 1'b0;
        chk("hrst_cyc_off", {31'b0, wbif.wbm_cyc_o}, 32'd0);
        slave_en = 1'b1;
        wait_resp(b + 1, "hrst_resp");
        idle(4);
        chk("hrst_no_write", n_acc - a, 32'd0);
        chk("hrst_one_resp", n_resp, b + 1);
        chk("hrst_status", r_status[b], 32'h0C);
        chk("hrst_addr", r_adr[b], 32'h0);
        chk("hrst_data", r_data[b], 32'h0);

        // Two ih_reset pulses before the host takes the response
        oh_ready = 1'b0; b = n_resp;
        ih_reset = 1'b1; step(); ih_reset = 1'b0; step();
        ih_reset = 1'b1; step(); ih_reset = 1'b0; idle(2);
        oh_ready = 1'b1;
        wait_resp(b + 1, "dbl_resp");
        idle(4);
        chk("dbl_single_resp", n_resp, b + 1);
        chk("dbl_status", r_status[b], 32'h0C);

        // READ across address wrap with oh_ready held low
        oh_ready = 1'b0; a = n_acc; b = n_resp; s0 = stab_err;
        send(32'h2, 32'hFFFFFFFF, 28'd2, 32'h0);
        idle(6);
        chk("wrap_no_oh_en", n_resp, b);
        chk("wrap_held_status", out_status, 32'h0C);
        chk("wrap_held_data", out_data, 32'h0);
        chk("wrap_stable", stab_err, s0);
        chk("wrap_one_acc", n_acc - a, 32'd1);
        chk("wrap_adr0", acc_adr[a], 32'hFFFFFFFF);
        oh_ready = 1'b1;
        wait_resp(b + 2, "wrap_resp");
        chk("wrap_adr1", acc_adr[a+1], 32'h0);
        chk("wrap_status0", r_status[b], 32'h0D);
        chk("wrap_addr0", r_adr[b], 32'hFFFFFFFF);
        chk("wrap_data0", r_data[b], 32'h33);
        chk("wrap_count0", {4'b0, r_cnt[b]}, 32'd1);
        chk("wrap_data1", r_data[b+1], 32'h44);
        chk("wrap_count1", {4'b0, r_cnt[b+1]}, 32'd0);

        // rst in the middle of a read abandons it without a response
        slave_en = 1'b0; b = n_resp;
        send(32'h2, 32'h80, 28'd1, 32'h0);
        chk("mrst_cyc_on", {31'b0, wbif.wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_cyc_off", {31'b0, wbif.wbm_cyc_o}, 32'd0);
        chk("mrst_out_status", out_status, 32'h0);
        rst = 1'b0;
        idle(6);
        chk("mrst_no_resp", n_resp, b);
        chk("mrst_out_addr", out_address, 32'h0);
        chk("mrst_ready", {31'b0, master_ready}, 32'd1);
        chk("out_stable_overall", stab_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
